// File: rtl/alu_rs_scheduler.sv
// ALU reservation station and issue scheduler.
// Holds decoded ALU-class instructions until both operands are present.
// Operands are captured from the ALU and LSB result broadcasts.
// At most one ready entry issues per cycle into registered ALU input ports.
// Optional build macro ALU_RS_AGE_PRIORITY_EN: each entry keeps a saturating
// age counter and selection picks the oldest ready entry. Without the macro,
// the lowest-index ready entry is picked.

module alu_rs_entry #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int PAY_W  = 8
`ifdef ALU_RS_AGE_PRIORITY_EN
    , parameter int AGE_W = 5
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              flush_i,
    input  logic              wr_i,
    input  logic              iss_i,
    input  logic [PAY_W-1:0]  pay_i,
    input  logic              qj_busy_i,
    input  logic [ROB_W-1:0]  qj_i,
    input  logic [DATA_W-1:0] vj_i,
    input  logic              qk_busy_i,
    input  logic [ROB_W-1:0]  qk_i,
    input  logic [DATA_W-1:0] vk_i,
    input  logic              alu_cdb_valid_i,
    input  logic [ROB_W-1:0]  alu_cdb_rob_i,
    input  logic [DATA_W-1:0] alu_cdb_data_i,
    input  logic              lsb_cdb_valid_i,
    input  logic [ROB_W-1:0]  lsb_cdb_rob_i,
    input  logic [DATA_W-1:0] lsb_cdb_data_i,
    output logic              valid_o,
    output logic              ready_o,
    output logic [PAY_W-1:0]  pay_o,
    output logic [DATA_W-1:0] vj_o,
    output logic [DATA_W-1:0] vk_o
`ifdef ALU_RS_AGE_PRIORITY_EN
    , output logic [AGE_W-1:0] age_o
`endif
);
    logic              valid_q, valid_d;
    logic [PAY_W-1:0]  pay_q, pay_d;
    logic              jb_q, jb_d, kb_q, kb_d;
    logic [ROB_W-1:0]  qj_q, qj_d, qk_q, qk_d;
    logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;

    // Next entry state: load or free, then wake up whatever operand state is
    // about to be stored (this also covers the same-cycle dispatch bypass).
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        jb_d    = jb_q;
        qj_d    = qj_q;
        vj_d    = vj_q;
        kb_d    = kb_q;
        qk_d    = qk_q;
        vk_d    = vk_q;
        if (wr_i) begin
            valid_d = 1'b1;
            pay_d   = pay_i;
            jb_d    = qj_busy_i;
            qj_d    = qj_i;
            vj_d    = vj_i;
            kb_d    = qk_busy_i;
            qk_d    = qk_i;
            vk_d    = vk_i;
        end else if (iss_i) begin
            valid_d = 1'b0;
        end
        if (jb_d && alu_cdb_valid_i && alu_cdb_rob_i == qj_d) begin
            jb_d = 1'b0;
            vj_d = alu_cdb_data_i;
        end else if (jb_d && lsb_cdb_valid_i && lsb_cdb_rob_i == qj_d) begin
            jb_d = 1'b0;
            vj_d = lsb_cdb_data_i;
        end
        if (kb_d && alu_cdb_valid_i && alu_cdb_rob_i == qk_d) begin
            kb_d = 1'b0;
            vk_d = alu_cdb_data_i;
        end else if (kb_d && lsb_cdb_valid_i && lsb_cdb_rob_i == qk_d) begin
            kb_d = 1'b0;
            vk_d = lsb_cdb_data_i;
        end
    end

    // Entry storage; only the valid bit needs a reset, payload is don't-care when invalid.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
        end else if (rdy_i) begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
            jb_q    <= jb_d;
            qj_q    <= qj_d;
            vj_q    <= vj_d;
            kb_q    <= kb_d;
            qk_q    <= qk_d;
            vk_q    <= vk_d;
        end
    end

`ifdef ALU_RS_AGE_PRIORITY_EN
    logic [AGE_W-1:0] age_q;

    // Saturating age: zero on dispatch, counts every enabled cycle while held.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            age_q <= '0;
        end else if (rdy_i) begin
            if (wr_i)
                age_q <= '0;
            else if (valid_q && age_q != {AGE_W{1'b1}})
                age_q <= age_q + AGE_W'(1);
        end
    end

    assign age_o = age_q;
`endif

    assign valid_o = valid_q;
    assign ready_o = valid_q && !jb_q && !kb_q;
    assign pay_o   = pay_q;
    assign vj_o    = vj_q;
    assign vk_o    = vk_q;
endmodule

module alu_rs_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              rollback_i,
    input  logic              dsp_valid_i,
    input  logic [6:0]        dsp_opcode_i,
    input  logic [2:0]        dsp_func3_i,
    input  logic              dsp_func1_i,
    input  logic              dsp_qj_busy_i,
    input  logic [ROB_W-1:0]  dsp_qj_i,
    input  logic [DATA_W-1:0] dsp_vj_i,
    input  logic              dsp_qk_busy_i,
    input  logic [ROB_W-1:0]  dsp_qk_i,
    input  logic [DATA_W-1:0] dsp_vk_i,
    input  logic [DATA_W-1:0] dsp_imm_i,
    input  logic [DATA_W-1:0] dsp_off_i,
    input  logic [DATA_W-1:0] dsp_pc_i,
    input  logic [ROB_W-1:0]  dsp_rob_i,
    input  logic              alu_cdb_valid_i,
    input  logic [ROB_W-1:0]  alu_cdb_rob_i,
    input  logic [DATA_W-1:0] alu_cdb_data_i,
    input  logic              lsb_cdb_valid_i,
    input  logic [ROB_W-1:0]  lsb_cdb_rob_i,
    input  logic [DATA_W-1:0] lsb_cdb_data_i,
    output logic              rs_full_o,
    output logic              alu_inst_valid_o,
    output logic [6:0]        alu_opcode_o,
    output logic [2:0]        alu_func3_o,
    output logic              alu_func1_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [DATA_W-1:0] alu_imm_o,
    output logic [DATA_W-1:0] alu_off_o,
    output logic [DATA_W-1:0] alu_pc_o,
    output logic [ROB_W-1:0]  alu_rob_target_o
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
`ifdef ALU_RS_AGE_PRIORITY_EN
    localparam int AGE_W = IDX_W + 1;
`endif

    // Fields that ride along untouched from dispatch to issue.
    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic              func1;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] off;
        logic [DATA_W-1:0] pc;
        logic [ROB_W-1:0]  rob;
    } pay_t;
    localparam int PAY_W = $bits(pay_t);

    pay_t              dsp_pay;
    logic              flush, dsp_fire;
    logic              rs_full_q;
    logic [RS_SIZE-1:0] valid_v, ready_v, wr_v, iss_v, nxt_valid;
    logic [PAY_W-1:0]  pay_v [RS_SIZE];
    logic [DATA_W-1:0] vj_v  [RS_SIZE];
    logic [DATA_W-1:0] vk_v  [RS_SIZE];
    logic              alloc_vld, iss_vld;
    logic [IDX_W-1:0]  alloc_idx, iss_idx;
`ifdef ALU_RS_AGE_PRIORITY_EN
    logic [AGE_W-1:0]  age_v [RS_SIZE];
    logic [AGE_W-1:0]  best_age;
`endif

    pay_t              alu_pay_q;
    logic              alu_vld_q;
    logic [DATA_W-1:0] alu_d1_q, alu_d2_q;

    assign flush    = rollback_i && rdy_i;
    assign dsp_fire = dsp_valid_i && !rs_full_q && alloc_vld;
    assign dsp_pay  = '{opcode: dsp_opcode_i, func3: dsp_func3_i, func1: dsp_func1_i,
                        imm: dsp_imm_i, off: dsp_off_i, pc: dsp_pc_i, rob: dsp_rob_i};

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ent
        alu_rs_entry #(
            .ROB_W (ROB_W),
            .DATA_W(DATA_W),
            .PAY_W (PAY_W)
`ifdef ALU_RS_AGE_PRIORITY_EN
            , .AGE_W(AGE_W)
`endif
        ) u_ent (
            .clk            (clk),
            .rst            (rst),
            .rdy_i          (rdy_i),
            .flush_i        (flush),
            .wr_i           (wr_v[g]),
            .iss_i          (iss_v[g]),
            .pay_i          (dsp_pay),
            .qj_busy_i      (dsp_qj_busy_i),
            .qj_i           (dsp_qj_i),
            .vj_i           (dsp_vj_i),
            .qk_busy_i      (dsp_qk_busy_i),
            .qk_i           (dsp_qk_i),
            .vk_i           (dsp_vk_i),
            .alu_cdb_valid_i(alu_cdb_valid_i),
            .alu_cdb_rob_i  (alu_cdb_rob_i),
            .alu_cdb_data_i (alu_cdb_data_i),
            .lsb_cdb_valid_i(lsb_cdb_valid_i),
            .lsb_cdb_rob_i  (lsb_cdb_rob_i),
            .lsb_cdb_data_i (lsb_cdb_data_i),
            .valid_o        (valid_v[g]),
            .ready_o        (ready_v[g]),
            .pay_o          (pay_v[g]),
            .vj_o           (vj_v[g]),
            .vk_o           (vk_v[g])
`ifdef ALU_RS_AGE_PRIORITY_EN
            , .age_o        (age_v[g])
`endif
        );
    end

    // Lowest-index free entry receives the dispatch.
    always_comb begin
        alloc_vld = 1'b0;
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_v[i]) begin
                alloc_vld = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

`ifdef ALU_RS_AGE_PRIORITY_EN
    // Oldest ready entry wins; strict compare keeps ties on the lowest index.
    always_comb begin
        iss_vld  = 1'b0;
        iss_idx  = '0;
        best_age = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_v[i] && (!iss_vld || age_v[i] > best_age)) begin
                iss_vld  = 1'b1;
                iss_idx  = IDX_W'(i);
                best_age = age_v[i];
            end
        end
    end
`else
    // Lowest-index ready entry wins.
    always_comb begin
        iss_vld = 1'b0;
        iss_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_v[i]) begin
                iss_vld = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end
`endif

    // One-hot write/free strobes and the occupancy the next edge will leave.
    always_comb begin
        wr_v  = '0;
        iss_v = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wr_v[i]  = dsp_fire && (alloc_idx == IDX_W'(i));
            iss_v[i] = iss_vld && (iss_idx == IDX_W'(i));
        end
        nxt_valid = wr_v | (valid_v & ~iss_v);
    end

    // Registered ALU issue port and full flag; payload holds when nothing issues.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rs_full_q <= 1'b0;
            alu_vld_q <= 1'b0;
            alu_pay_q <= '0;
            alu_d1_q  <= '0;
            alu_d2_q  <= '0;
        end else if (rdy_i) begin
            rs_full_q <= &nxt_valid;
            alu_vld_q <= iss_vld;
            if (iss_vld) begin
                alu_pay_q <= pay_t'(pay_v[iss_idx]);
                alu_d1_q  <= vj_v[iss_idx];
                alu_d2_q  <= vk_v[iss_idx];
            end
        end
    end

    assign rs_full_o        = rs_full_q;
    assign alu_inst_valid_o = alu_vld_q;
    assign alu_opcode_o     = alu_pay_q.opcode;
    assign alu_func3_o      = alu_pay_q.func3;
    assign alu_func1_o      = alu_pay_q.func1;
    assign alu_data1_o      = alu_d1_q;
    assign alu_data2_o      = alu_d2_q;
    assign alu_imm_o        = alu_pay_q.imm;
    assign alu_off_o        = alu_pay_q.off;
    assign alu_pc_o         = alu_pay_q.pc;
    assign alu_rob_target_o = alu_pay_q.rob;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler (RS_SIZE=16, ROB_W=4, DATA_W=32).
module tb_alu_rs_scheduler;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    logic        clk, rst, rdy, rollback;
    logic        dsp_valid, dsp_func1, dsp_qj_busy, dsp_qk_busy;
    logic [6:0]  dsp_opcode;
    logic [2:0]  dsp_func3;
    logic [3:0]  dsp_qj, dsp_qk, dsp_rob;
    logic [31:0] dsp_vj, dsp_vk, dsp_imm, dsp_off, dsp_pc;
    logic        alu_cdb_valid, lsb_cdb_valid;
    logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
    logic [31:0] alu_cdb_data, lsb_cdb_data;
    logic        rs_full, alu_inst_valid, alu_func1;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic [31:0] alu_data1, alu_data2, alu_imm, alu_off, alu_pc;
    logic [3:0]  alu_rob_target;

    int checks = 0;
    int failures = 0;

    alu_rs_scheduler #(.RS_SIZE(16), .ROB_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy_i(rdy), .rollback_i(rollback),
        .dsp_valid_i(dsp_valid), .dsp_opcode_i(dsp_opcode), .dsp_func3_i(dsp_func3),
        .dsp_func1_i(dsp_func1), .dsp_qj_busy_i(dsp_qj_busy), .dsp_qj_i(dsp_qj),
        .dsp_vj_i(dsp_vj), .dsp_qk_busy_i(dsp_qk_busy), .dsp_qk_i(dsp_qk),
        .dsp_vk_i(dsp_vk), .dsp_imm_i(dsp_imm), .dsp_off_i(dsp_off), .dsp_pc_i(dsp_pc),
        .dsp_rob_i(dsp_rob),
        .alu_cdb_valid_i(alu_cdb_valid), .alu_cdb_rob_i(alu_cdb_rob), .alu_cdb_data_i(alu_cdb_data),
        .lsb_cdb_valid_i(lsb_cdb_valid), .lsb_cdb_rob_i(lsb_cdb_rob), .lsb_cdb_data_i(lsb_cdb_data),
        .rs_full_o(rs_full), .alu_inst_valid_o(alu_inst_valid), .alu_opcode_o(alu_opcode),
        .alu_func3_o(alu_func3), .alu_func1_o(alu_func1), .alu_data1_o(alu_data1),
        .alu_data2_o(alu_data2), .alu_imm_o(alu_imm), .alu_off_o(alu_off), .alu_pc_o(alu_pc),
        .alu_rob_target_o(alu_rob_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dsp_valid = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
        rollback = 1'b0;
    endtask

    task automatic drive_dsp(input logic [6:0] op, input logic qjb, input logic [3:0] qj,
                             input logic [31:0] vj, input logic qkb, input logic [3:0] qk,
                             input logic [31:0] vk, input logic [31:0] imm, input logic [3:0] rob);
        dsp_valid = 1'b1; dsp_opcode = op; dsp_func3 = 3'd0; dsp_func1 = 1'b0;
        dsp_qj_busy = qjb; dsp_qj = qj; dsp_vj = vj;
        dsp_qk_busy = qkb; dsp_qk = qk; dsp_vk = vk;
        dsp_imm = imm; dsp_off = 32'h20; dsp_pc = 32'h1000 + 32'(rob) * 4; dsp_rob = rob;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; idle();
        drive_dsp(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0); dsp_valid = 1'b0;
        alu_cdb_rob = 0; alu_cdb_data = 0; lsb_cdb_rob = 0; lsb_cdb_data = 0;
        step(); step();
        rst = 1'b0;
        checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", rs_full); end
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", alu_inst_valid); end
        checks++; if (alu_data1 !== 32'h0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", alu_data1); end
        checks++; if (alu_rob_target !== 4'h0) begin failures++; $display("FAIL reset_rob got=%h exp=0", alu_rob_target); end
    endtask

    task automatic test_ready_dispatch();
        drive_dsp(OP_ADDI, 0, 0, 32'd5, 0, 0, 0, 32'd7, 4'd3);
        step(); idle();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL rd_cyc1_valid got=%b exp=0", alu_inst_valid); end
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL rd_issue_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_data1 !== 32'd5) begin failures++; $display("FAIL rd_data1 got=%h exp=5", alu_data1); end
        checks++; if (alu_imm !== 32'd7) begin failures++; $display("FAIL rd_imm got=%h exp=7", alu_imm); end
        checks++; if (alu_rob_target !== 4'd3) begin failures++; $display("FAIL rd_rob got=%h exp=3", alu_rob_target); end
        checks++; if (alu_opcode !== OP_ADDI) begin failures++; $display("FAIL rd_opcode got=%b exp=%b", alu_opcode, OP_ADDI); end
        checks++; if (alu_pc !== 32'h100C) begin failures++; $display("FAIL rd_pc got=%h exp=100c", alu_pc); end
        step();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL rd_freed_valid got=%b exp=0", alu_inst_valid); end
        checks++; if (alu_data1 !== 32'd5) begin failures++; $display("FAIL rd_hold_data1 got=%h exp=5", alu_data1); end
    endtask

    task automatic test_cdb_wakeup();
        drive_dsp(OP_ADD, 1, 4'd2, 0, 0, 0, 32'd10, 0, 4'd6);
        step(); idle();
        step(); step(); step();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL wk_wait_valid got=%b exp=0", alu_inst_valid); end
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd2; alu_cdb_data = 32'h20;
        step(); idle();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL wk_capture_valid got=%b exp=0", alu_inst_valid); end
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL wk_issue_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_data1 !== 32'h20) begin failures++; $display("FAIL wk_data1 got=%h exp=20", alu_data1); end
        checks++; if (alu_data2 !== 32'd10) begin failures++; $display("FAIL wk_data2 got=%h exp=a", alu_data2); end
        step();
    endtask

    task automatic test_bypass();
        drive_dsp(OP_ADD, 0, 0, 32'd1, 1, 4'd5, 0, 0, 4'd7);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd5; lsb_cdb_data = 32'hFFFF_FFFF;
        step(); idle();
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_data2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL bp_data2 got=%h exp=ffffffff", alu_data2); end
        checks++; if (alu_data1 !== 32'd1) begin failures++; $display("FAIL bp_data1 got=%h exp=1", alu_data1); end
        checks++; if (alu_rob_target !== 4'd7) begin failures++; $display("FAIL bp_rob got=%h exp=7", alu_rob_target); end
        step();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL bp_after_valid got=%b exp=0", alu_inst_valid); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive_dsp(OP_ADD, 1, 4'(i), 0, 0, 0, 32'(i), 0, 4'(i));
            step();
            if (i == 14) begin
                checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL full_at15 got=%b exp=0", rs_full); end
            end
        end
        checks++; if (rs_full !== 1'b1) begin failures++; $display("FAIL full_at16 got=%b exp=1", rs_full); end
        // held dispatch while full, plus wakeup of entry 7
        drive_dsp(OP_ADDI, 0, 0, 32'h99, 0, 0, 0, 32'd1, 4'd9);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd7; alu_cdb_data = 32'h77;
        step(); alu_cdb_valid = 1'b0;
        checks++; if (rs_full !== 1'b1) begin failures++; $display("FAIL full_capture got=%b exp=1", rs_full); end
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL full_capture_valid got=%b exp=0", alu_inst_valid); end
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL full_issue_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_data1 !== 32'h77) begin failures++; $display("FAIL full_issue_data1 got=%h exp=77", alu_data1); end
        checks++; if (alu_data2 !== 32'd7) begin failures++; $display("FAIL full_issue_data2 got=%h exp=7", alu_data2); end
        checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL full_drop got=%b exp=0", rs_full); end
        step(); idle();
        checks++; if (rs_full !== 1'b1) begin failures++; $display("FAIL full_accept got=%b exp=1", rs_full); end
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL full_accept_valid got=%b exp=0", alu_inst_valid); end
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL full_held_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_data1 !== 32'h99) begin failures++; $display("FAIL full_held_data1 got=%h exp=99", alu_data1); end
        checks++; if (alu_rob_target !== 4'd9) begin failures++; $display("FAIL full_held_rob got=%h exp=9", alu_rob_target); end
        checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL full_held_free got=%b exp=0", rs_full); end
    endtask

    task automatic test_rollback();
        rollback = 1'b1;
        step(); idle();
        checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL rb1_full got=%b exp=0", rs_full); end
        checks++; if (alu_data1 !== 32'h0) begin failures++; $display("FAIL rb1_data1 got=%h exp=0", alu_data1); end
        checks++; if (alu_rob_target !== 4'h0) begin failures++; $display("FAIL rb1_rob got=%h exp=0", alu_rob_target); end
        for (int i = 0; i < 6; i++) begin
            drive_dsp(OP_ADD, 1, 4'(i), 0, 0, 0, 0, 0, 4'(i));
            step();
        end
        drive_dsp(OP_ADDI, 0, 0, 32'h55, 0, 0, 0, 32'd1, 4'd10);
        rollback = 1'b1;
        step(); idle();
        checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL rb2_full got=%b exp=0", rs_full); end
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL rb2_valid got=%b exp=0", alu_inst_valid); end
        for (int k = 0; k < 5; k++) begin
            alu_cdb_valid = 1'b1; alu_cdb_rob = 4'(k); alu_cdb_data = 32'(k);
            step();
            checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL rb_quiet%0d got=%b exp=0", k, alu_inst_valid); end
        end
        idle();
        step();
    endtask

    task automatic test_rdy_age();
        logic [3:0]  rob1, rob2;
        logic [31:0] d1, d2;
`ifdef ALU_RS_AGE_PRIORITY_EN
        rob1 = 4'd4;  d1 = 32'h44; rob2 = 4'd14; d2 = 32'h11;
`else
        rob1 = 4'd14; d1 = 32'h11; rob2 = 4'd4;  d2 = 32'h44;
`endif
        for (int i = 0; i < 5; i++) begin
            drive_dsp(OP_ADD, 1, 4'(8 + i), 0, 0, 0, 0, 0, 4'(i));
            step();
        end
        idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd9; alu_cdb_data = 32'h9;
        step(); idle();
        step();
        checks++; if (alu_rob_target !== 4'd1) begin failures++; $display("FAIL age_e1_rob got=%h exp=1", alu_rob_target); end
        // index 1 refilled with a newer instruction
        drive_dsp(OP_ADD, 1, 4'd13, 0, 0, 0, 0, 0, 4'd14);
        step(); idle();
        step();
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd12; alu_cdb_data = 32'h44;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd13; lsb_cdb_data = 32'h11;
        step(); idle();
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL age_first_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_rob_target !== rob1) begin failures++; $display("FAIL age_first_rob got=%h exp=%h", alu_rob_target, rob1); end
        checks++; if (alu_data1 !== d1) begin failures++; $display("FAIL age_first_data1 got=%h exp=%h", alu_data1, d1); end
        // freeze: dispatch and broadcast must both be ignored
        rdy = 1'b0;
        drive_dsp(OP_ADDI, 0, 0, 32'hAB, 0, 0, 0, 0, 4'd15);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd8; alu_cdb_data = 32'h88;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL frz%0d_valid got=%b exp=1", k, alu_inst_valid); end
            checks++; if (alu_rob_target !== rob1) begin failures++; $display("FAIL frz%0d_rob got=%h exp=%h", k, alu_rob_target, rob1); end
        end
        rdy = 1'b1; idle();
        step();
        checks++; if (alu_inst_valid !== 1'b1) begin failures++; $display("FAIL age_second_valid got=%b exp=1", alu_inst_valid); end
        checks++; if (alu_rob_target !== rob2) begin failures++; $display("FAIL age_second_rob got=%h exp=%h", alu_rob_target, rob2); end
        checks++; if (alu_data1 !== d2) begin failures++; $display("FAIL age_second_data1 got=%h exp=%h", alu_data1, d2); end
        step();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL age_tail0 got=%b exp=0", alu_inst_valid); end
        step();
        checks++; if (alu_inst_valid !== 1'b0) begin failures++; $display("FAIL age_tail1 got=%b exp=0", alu_inst_valid); end
        checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL age_full got=%b exp=0", rs_full); end
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_bypass();
        test_full();
        test_rollback();
        test_rdy_age();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler for the integer ALU in the Tomasulo core.
- Accepts decoded ALU-class instructions from the decoder: ARITH, ARITHI, LUI, AUIPC, B, JAL, JALR.
- Holds them until both source operands are available, capturing operands by snooping the ALU and LSB result broadcasts.
- Issues at most one ready instruction per cycle to the ALU through registered ALU input ports; flushed on rollback.

Parameters:
- RS_SIZE, 16, number of entries; power of two, 2..32.
- ROB_W, 4, ROB index width.
- DATA_W, 32, operand/PC width.

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  misprediction flush
- dsp_valid  in  1  dispatch request
- dsp_opcode  in  7  opcode
- dsp_func3  in  3  func3
- dsp_func1  in  1  func7[5]
- dsp_qj_busy  in  1  rs1 value pending
- dsp_qj  in  ROB_W  rs1 producer tag
- dsp_vj  in  DATA_W  rs1 value when not busy
- dsp_qk_busy  in  1  rs2 value pending
- dsp_qk  in  ROB_W  rs2 producer tag
- dsp_vk  in  DATA_W  rs2 value when not busy
- dsp_imm  in  DATA_W  immediate
- dsp_off  in  DATA_W  branch/jump offset
- dsp_pc  in  DATA_W  instruction PC
- dsp_rob  in  ROB_W  destination ROB id
- alu_cdb_valid / alu_cdb_rob / alu_cdb_data  in  1 / ROB_W / DATA_W  ALU broadcast
- lsb_cdb_valid / lsb_cdb_rob / lsb_cdb_data  in  1 / ROB_W / DATA_W  LSB broadcast
- rs_full  out  1  no free entry (registered)
- alu_inst_valid  out  1  issue strobe to ALU
- alu_opcode, alu_func3, alu_func1  out  7, 3, 1  issued fields
- alu_data1, alu_data2, alu_imm, alu_off, alu_pc  out  DATA_W  issued operands
- alu_rob_target  out  ROB_W  issued destination

Behaviour:
- Reset, or rollback while rdy: all entries invalid; all outputs 0. Rollback takes priority over dispatch, issue and snoop in the same cycle.
- rdy low: no state or output changes; dispatch is ignored and the decoder must hold.
- Entry fields: valid, opcode, func3, func1, qj_busy, qj, vj, qk_busy, qk, vk, imm, off, pc, rob.
- Dispatch:
  - When dsp_valid && !rs_full, the lowest-index free entry is written at the clock edge.
  - Decoder must not assert dsp_valid while rs_full.
  - Same-cycle bypass: if qj_busy and a valid CDB carries tag qj, the entry stores the CDB data with qj_busy=0. Same rule for qk.
- Snoop: every cycle, each valid entry with qj_busy and a tag match on either CDB captures the data and clears qj_busy. Same rule for qk. Both CDBs matching the same tag cannot occur (ROB ids are unique).
- Ready: valid && !qj_busy && !qk_busy, evaluated on registered entry state.
  - A dispatched entry is first eligible the cycle after it is written.
  - An operand captured by snoop is usable the cycle after capture.
- Selection: lowest-index ready entry.
- Issue:
  - At the edge, the selected entry's fields are loaded into the alu_* registers, alu_inst_valid<=1, and the entry is freed.
  - With no ready entry, alu_inst_valid<=0; the other alu_* outputs hold their values.
  - Issue latency: ready cycle N, alu_inst_valid high in cycle N+1.
  - Best case, dispatch-to-ALU-result is 3 edges.
- Dispatch and issue in the same cycle: both take effect. A freed entry is reusable from the next cycle.
- rs_full: registered; equals (free count after this edge == 0).
- LUI, AUIPC and JAL dispatch with qj_busy=qk_busy=0.

Optional Feature:
- Macro: ALU_RS_AGE_PRIORITY_EN.
- Defined: each entry has a saturating age counter of log2(RS_SIZE)+1 bits.
  - Cleared at dispatch; incremented each rdy cycle while valid.
  - Selection picks the highest age, with ties going to the lowest index (oldest-first).
- Undefined: no age counters; pure lowest-index selection.

Test Plan:
- Ready dispatch: ADDI with vj=5, imm=7, rob=3 at cycle 0, both operands ready. alu_inst_valid=1 in cycle 2 with data1=5, imm=7, rob_target=3, and the entry is freed.
- CDB wakeup: ADD with qj=2 busy, vk=10. ALU CDB broadcasts rob=2, data=0x20 in cycle 4. Issue occurs in cycle 6 with data1=0x20, data2=10.
- Same-cycle bypass: dispatch with qk=5 busy while lsb_cdb broadcasts rob=5, data=0xFFFF_FFFF. The entry is ready the next cycle with data2=0xFFFF_FFFF.
- Full: 16 dispatches with unresolved tags give rs_full=1 after the 16th edge. One wakeup plus issue drops rs_full to 0 the edge after issue; a dispatch held during full is then accepted.
- Rollback: 6 valid entries plus simultaneous dispatch and rollback. Afterwards rs_full=0, alu_inst_valid=0, and no issue occurs for 5 cycles.
- rdy gating and age priority: rdy=0 for 3 cycles freezes alu_* and entries. With ALU_RS_AGE_PRIORITY_EN, ready entries at index 4 (older) and index 1 (newer) issue index 4 first; without the macro, index 1 issues first.
